// File: rtl/pipe_elastic_rx.sv
// pipe_elastic_rx: elastic byte pipeline with per-stage valid bits; PIPE_ELASTIC_RX_PARITY_EN adds parity carry/check
module pipe_elastic_rx #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 3
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  input  logic [WIDTH-1:0]           in_data,
`ifdef PIPE_ELASTIC_RX_PARITY_EN
  input  logic                       in_par,
  output logic                       out_par_err,
`endif
  output logic                       in_ready,
  output logic                       out_valid,
  output logic [WIDTH-1:0]           out_data,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int CW = $clog2(DEPTH+1);
  logic [DEPTH:1]   vld;
  logic [DEPTH:1]   acc;
  logic [WIDTH-1:0] dat [1:DEPTH];
  genvar k;
  // a stage can take new content when it or any stage downstream has room, or the output drains
  for (k = 1; k <= DEPTH; k++) begin : g_acc
    assign acc[k] = out_ready | ~(&vld[DEPTH:k]);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      vld <= '0;
      for (int i = 1; i <= DEPTH; i++) dat[i] <= '0;
    end else begin
      if (acc[1]) vld[1] <= in_valid;
      if (acc[1] && in_valid) dat[1] <= in_data;
      for (int i = 2; i <= DEPTH; i++) begin
        if (acc[i]) vld[i] <= vld[i-1];
        if (acc[i] && vld[i-1]) dat[i] <= dat[i-1];
      end
    end
  always_comb begin
    count = '0;
    for (int i = 1; i <= DEPTH; i++) count = count + CW'(vld[i]);
  end
  assign in_ready  = acc[1];
  assign out_valid = vld[DEPTH];
  assign out_data  = dat[DEPTH];
`ifdef PIPE_ELASTIC_RX_PARITY_EN
  logic [DEPTH:1] par;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) par <= '0;
    else begin
      if (acc[1] && in_valid) par[1] <= in_par;
      for (int i = 2; i <= DEPTH; i++)
        if (acc[i] && vld[i-1]) par[i] <= par[i-1];
    end
  assign out_par_err = vld[DEPTH] & ((^dat[DEPTH]) ^ par[DEPTH]);
`endif
endmodule

// File: tb/tb_pipe_elastic_rx.sv
// tb_pipe_elastic_rx: directed and scoreboard checks of the elastic receive pipeline
module tb_pipe_elastic_rx;
  logic       clk = 0;
  logic       rst_n = 0;
  logic       in_valid = 0;
  logic       out_ready = 0;
  logic [7:0] in_data = 0;
  logic       in_ready, out_valid;
  logic [7:0] out_data;
  logic [1:0] count;
`ifdef PIPE_ELASTIC_RX_PARITY_EN
  logic       in_par = 0;
  logic       out_par_err;
`endif
  int         errors = 0;
  int         checks = 0;
  int         acc;
  logic       hs, ov;
  logic [7:0] od, exp_b;
  logic [7:0] q [$];

  pipe_elastic_rx #(.WIDTH(8), .DEPTH(3)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
`ifdef PIPE_ELASTIC_RX_PARITY_EN
    .in_par(in_par), .out_par_err(out_par_err),
`endif
    .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
    .out_ready(out_ready), .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    #1;
    hs = in_valid & in_ready;
    ov = out_valid & out_ready;
    od = out_data;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    #12;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_count", count, 0);
    rst_n = 1;
    #1;
    chk("rst_in_ready", in_ready, 1);
    // streaming with free output
    out_ready = 1;
    in_valid = 1; in_data = 8'h11; cyc();
    in_data = 8'h22; cyc();
    in_data = 8'h33;
    chk("lat_not_yet", out_valid, 0);
    cyc();
    chk("lat_valid", out_valid, 1);
    chk("lat_data", out_data, 8'h11);
    chk("stream_count", count, 3);
    in_data = 8'h44; cyc();
    chk("stream_d22", out_data, 8'h22);
    in_valid = 0; cyc();
    chk("stream_d33", out_data, 8'h33);
    cyc();
    chk("stream_d44", out_data, 8'h44);
    cyc();
    chk("stream_empty", out_valid, 0);
    chk("stream_empty_cnt", count, 0);
    // backpressure fill then release
    out_ready = 0; acc = 0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1; in_data = 8'hA0 + acc[7:0];
      cyc();
      if (hs) acc++;
    end
    chk("bp_accepted", acc, 3);
    chk("bp_count", count, 3);
    chk("bp_in_ready", in_ready, 0);
    out_ready = 1;
    for (int i = 0; i < 5; i++) begin
      in_valid = (acc < 5); in_data = 8'hA0 + acc[7:0];
      cyc();
      chk("bp_out_valid", ov, 1);
      chk("bp_out_data", od, 8'hA0 + i);
      if (hs) acc++;
    end
    chk("bp_drained", count, 0);
    // full pipe with simultaneous in/out transfer
    out_ready = 0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1; in_data = 8'(i + 1);
      cyc();
    end
    in_data = 8'h5C;
    #1;
    chk("full_in_ready0", in_ready, 0);
    chk("full_count", count, 3);
    out_ready = 1;
    #1;
    chk("full_in_ready1", in_ready, 1);
    cyc();
    chk("full_out_taken", ov, 1);
    chk("full_out_byte", od, 8'h01);
    chk("full_in_taken", hs, 1);
    chk("full_count_hold", count, 3);
    chk("full_next", out_data, 8'h02);
    in_valid = 0; cyc(); cyc();
    chk("full_5c_out", out_data, 8'h5C);
    cyc();
    chk("full_empty", count, 0);
    // randomized traffic against a queue model
    for (int i = 0; i < 1000; i++) begin
      in_valid = ($urandom_range(0, 9) < 7);
      in_data = 8'($urandom);
      out_ready = 1'($urandom_range(0, 1));
      #1;
      chk("rnd_in_ready", in_ready, (q.size() < 3) || out_ready);
      cyc();
      if (ov) begin
        exp_b = (q.size() > 0) ? q.pop_front() : 8'hxx;
        chk("rnd_data", od, exp_b);
      end
      if (hs) q.push_back(in_data);
      chk("rnd_count", count, q.size());
    end
    in_valid = 0; out_ready = 1;
    for (int i = 0; i < 6; i++) begin
      cyc();
      if (ov) begin
        exp_b = (q.size() > 0) ? q.pop_front() : 8'hxx;
        chk("rnd_drain", od, exp_b);
      end
    end
    chk("rnd_q_empty", q.size(), 0);
    chk("rnd_cnt_empty", count, 0);
    // asynchronous reset mid-stream
    out_ready = 0;
    in_valid = 1; in_data = 8'h61; cyc();
    in_data = 8'h62; cyc();
    in_valid = 0; cyc();
    chk("mid_count", count, 2);
    chk("mid_out_valid", out_valid, 1);
    chk("mid_out_data", out_data, 8'h61);
    #2 rst_n = 0;
    #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_out_data", out_data, 0);
    chk("arst_count", count, 0);
    #1 rst_n = 1;
    #1;
    chk("arst_in_ready", in_ready, 1);
    out_ready = 1; in_valid = 1; in_data = 8'h7E; cyc();
    in_valid = 0; cyc();
    chk("post_rst_lat", out_valid, 0);
    cyc();
    chk("post_rst_valid", out_valid, 1);
    chk("post_rst_data", out_data, 8'h7E);
`ifdef PIPE_ELASTIC_RX_PARITY_EN
    cyc();
    in_valid = 1; in_data = 8'h03; in_par = 1; cyc();
    in_par = 0; cyc();
    in_valid = 0; cyc();
    chk("par_bad", out_par_err, 1);
    cyc();
    chk("par_good", out_par_err, 0);
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
